hvac_zone_scheduler: RTL and testbench

//  Shares one heat/cool unit between NZONES thermostat zones. Each zone supplies power plus a 2-bit

---
 rtl/hvac_zone_scheduler.sv | 255 +++++++++++++++++++++++++
 tb/tb_hvac_zone_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hvac_zone_scheduler.sv
// Purpose: shares one heat/cool unit between NZONES thermostat zones (round-robin, min run, changeover dead time).
// Latency: outputs are registered; a request seen in IDLE is granted (RUN) on the next clock edge.
// Backpressure: none; zone inputs are levels sampled every cycle and the unit driver always accepts the action.
module hvac_zone_scheduler #(
  parameter int NZONES    = 4,
  parameter int ID_W      = 2,
  parameter int MIN_RUN   = 8,
  parameter int DEAD_TIME = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NZONES-1:0]     zone_power,
  input  logic [2*NZONES-1:0]   zone_temp_comp,
  output logic [1:0]            action,
  output logic [1:0]            state_display,
  output logic                  grant_valid,
  output logic [ID_W-1:0]       grant_id,
  output logic [NZONES-1:0]     damper
);

  localparam int RUN_W  = $clog2(MIN_RUN + 1);
  localparam int DEAD_W = $clog2(DEAD_TIME + 1);

  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(MIN_RUN);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_TIME - 1);

  localparam logic [1:0] ACT_OFF  = 2'b11;
  localparam logic [1:0] ACT_COOL = 2'b01;
  localparam logic [1:0] ACT_HEAT = 2'b10;
  localparam logic [1:0] ACT_IDLE = 2'b00;

  // Encodings double as the state_display code.
  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2,
    ST_IDLE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    M_NONE = 2'd0,
    M_COOL = 2'd1,
    M_HEAT = 2'd2
  } mode_e;

  // Reset synchronizer: assertion is immediate, release is aligned to clk.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  // Two-flop release synchronizer for the asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  // State and bookkeeping registers.
  state_e            state_q,     state_d;
  mode_e             last_mode_q, last_mode_d;
  logic              run_heat_q,  run_heat_d;   // latched mode of the current grant (1 = heat)
  logic [ID_W-1:0]   gid_q,       gid_d;        // latched granted zone
  logic [ID_W-1:0]   rr_ptr_q,    rr_ptr_d;
  logic [RUN_W-1:0]  run_cnt_q,   run_cnt_d;
  logic [DEAD_W-1:0] dead_cnt_q,  dead_cnt_d;

  // Registered outputs.
  logic [1:0]        action_q,    action_d;
  logic              gvalid_q,    gvalid_d;
  logic [ID_W-1:0]   gid_out_q,   gid_out_d;
  logic [NZONES-1:0] damper_q,    damper_d;

  // Per-zone request decode.
  logic [NZONES-1:0] req;
  logic [NZONES-1:0] heat;
  logic [1:0]        tc;

  // Decode each zone's comparator into a request and its wanted mode.
  always_comb begin
    req  = '0;
    heat = '0;
    tc   = 2'b00;
    for (int i = 0; i < NZONES; i++) begin
      tc      = zone_temp_comp[2*i +: 2];
      req[i]  = zone_power[i] & ((tc == 2'b10) | (tc == 2'b01));
      heat[i] = (tc == 2'b01);
    end
  end

  // Round-robin arbiter.
  logic            win_found;
  logic [ID_W-1:0] win_id;
  logic            win_heat;
  mode_e           win_mode;

  // Pick the first requesting zone scanning upward from rr_ptr+1, wrapping at NZONES.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_heat  = 1'b0;
    for (int k = 1; k <= NZONES; k++) begin
      for (int j = 0; j < NZONES; j++) begin
        if (!win_found && req[j] && (j == ((int'(rr_ptr_q) + k) % NZONES))) begin
          win_found = 1'b1;
          win_id    = ID_W'(j);
          win_heat  = heat[j];
        end
      end
    end
  end

  assign win_mode = win_heat ? M_HEAT : M_COOL;

  // Status of the currently granted zone.
  logic [NZONES-1:0] g_onehot;
  logic              g_pwr;
  logic              g_req;
  logic              g_heat;
  logic              other_req;

  // Look up power/request/mode of the granted zone and whether anyone else is waiting.
  always_comb begin
    g_onehot = '0;
    for (int i = 0; i < NZONES; i++) begin
      g_onehot[i] = (gid_q == ID_W'(i));
    end
    g_pwr     = |(zone_power & g_onehot);
    g_req     = |(req & g_onehot);
    g_heat    = |(heat & g_onehot);
    other_req = |(req & ~g_onehot);
  end

  // Next-state logic; loss of all zone power overrides every state.
  always_comb begin
    state_d     = state_q;
    last_mode_d = last_mode_q;
    run_heat_d  = run_heat_q;
    gid_d       = gid_q;
    rr_ptr_d    = rr_ptr_q;
    run_cnt_d   = run_cnt_q;
    dead_cnt_d  = dead_cnt_q;

    if (zone_power == '0) begin
      state_d     = ST_OFF;
      last_mode_d = M_NONE;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_IDLE;
        end

        ST_IDLE: begin
          if (win_found) begin
            if ((last_mode_q == M_NONE) || (last_mode_q == win_mode)) begin
              state_d     = ST_RUN;
              gid_d       = win_id;
              run_heat_d  = win_heat;
              run_cnt_d   = '0;
              last_mode_d = win_mode;
              rr_ptr_d    = win_id;
            end else begin
              // Changeover: the winner is not latched; it is re-arbitrated after the dead time.
              state_d    = ST_DEAD;
              dead_cnt_d = '0;
            end
          end
        end

        ST_RUN: begin
          if (run_cnt_q != RUN_MAX) begin
            run_cnt_d = run_cnt_q + RUN_W'(1);
          end
          if (!g_pwr) begin
            state_d = ST_IDLE;
          end else if ((run_cnt_q == RUN_MAX) &&
                       (!g_req || (g_heat != run_heat_q) || other_req)) begin
            state_d = ST_IDLE;
          end
        end

        ST_DEAD: begin
          if (dead_cnt_q == DEAD_LAST) begin
            state_d     = ST_IDLE;
            last_mode_d = M_NONE;
          end else begin
            dead_cnt_d = dead_cnt_q + DEAD_W'(1);
          end
        end

        default: begin
          state_d = ST_OFF;
        end
      endcase
    end
  end

  // Output values for the state being entered, so outputs come straight from flops.
  always_comb begin
    action_d  = ACT_IDLE;
    gvalid_d  = 1'b0;
    gid_out_d = '0;
    damper_d  = '0;
    case (state_d)
      ST_OFF:  action_d = ACT_OFF;
      ST_RUN: begin
        action_d  = run_heat_d ? ACT_HEAT : ACT_COOL;
        gvalid_d  = 1'b1;
        gid_out_d = gid_d;
        for (int i = 0; i < NZONES; i++) begin
          damper_d[i] = (gid_d == ID_W'(i));
        end
      end
      default: action_d = ACT_IDLE;
    endcase
  end

  // FSM and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_OFF;
      last_mode_q <= M_NONE;
      run_heat_q  <= 1'b0;
      gid_q       <= '0;
      rr_ptr_q    <= ID_W'(NZONES - 1);
      run_cnt_q   <= '0;
      dead_cnt_q  <= '0;
      action_q    <= ACT_OFF;
      gvalid_q    <= 1'b0;
      gid_out_q   <= '0;
      damper_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_mode_q <= last_mode_d;
      run_heat_q  <= run_heat_d;
      gid_q       <= gid_d;
      rr_ptr_q    <= rr_ptr_d;
      run_cnt_q   <= run_cnt_d;
      dead_cnt_q  <= dead_cnt_d;
      action_q    <= action_d;
      gvalid_q    <= gvalid_d;
      gid_out_q   <= gid_out_d;
      damper_q    <= damper_d;
    end
  end

  assign state_display = state_q;
  assign action        = action_q;
  assign grant_valid   = gvalid_q;
  assign grant_id      = gid_out_q;
  assign damper        = damper_q;

endmodule

// File: tb/tb_hvac_zone_scheduler.sv
// Purpose: directed self-checking bench for hvac_zone_scheduler with default parameters.
// Latency: one check per observed cycle, sampled 1 time unit after the rising edge.
// Backpressure: not applicable; stimulus is a fixed sequence of input levels.
module tb_hvac_zone_scheduler;

  localparam logic [1:0] S_OFF  = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DEAD = 2'd2;
  localparam logic [1:0] S_IDLE = 2'd3;

  localparam logic [1:0] A_OFF  = 2'b11;
  localparam logic [1:0] A_COOL = 2'b01;
  localparam logic [1:0] A_HEAT = 2'b10;
  localparam logic [1:0] A_IDLE = 2'b00;

  logic       clk;
  logic       reset_n;
  logic [3:0] zone_power;
  logic [7:0] zone_temp_comp;
  logic [1:0] action;
  logic [1:0] state_display;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic [3:0] damper;

  int checks;
  int errors;

  hvac_zone_scheduler #(
    .NZONES(4), .ID_W(2), .MIN_RUN(8), .DEAD_TIME(4)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .zone_power     (zone_power),
    .zone_temp_comp (zone_temp_comp),
    .action         (action),
    .state_display  (state_display),
    .grant_valid    (grant_valid),
    .grant_id       (grant_id),
    .damper         (damper)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] st, input logic [1:0] act,
                     input logic gv, input logic [1:0] gid, input logic [3:0] dmp);
    logic [10:0] obs;
    logic [10:0] exp;
    obs = {state_display, action, grant_valid, grant_id, damper};
    exp = {st, act, gv, gid, dmp};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed st=%0d act=%b gv=%b id=%0d dmp=%b, expected st=%0d act=%b gv=%b id=%0d dmp=%b",
             tag, obs[10:9], obs[8:7], obs[6], obs[5:4], obs[3:0],
             exp[10:9], exp[8:7], exp[6], exp[5:4], exp[3:0]);
    end
  endtask

  task automatic chk_run(input string tag, input logic [1:0] gid, input logic [1:0] act);
    logic [3:0] d;
    d = 4'b0001 << gid;
    chk(tag, S_RUN, act, 1'b1, gid, d);
  endtask

  task automatic chk_off(input string tag);
    chk(tag, S_OFF, A_OFF, 1'b0, 2'd0, 4'b0000);
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, S_IDLE, A_IDLE, 1'b0, 2'd0, 4'b0000);
  endtask

  task automatic chk_dead(input string tag);
    chk(tag, S_DEAD, A_IDLE, 1'b0, 2'd0, 4'b0000);
  endtask

  initial begin
    logic [1:0] exp_gid;
    checks         = 0;
    errors         = 0;
    reset_n        = 1'b0;
    zone_power     = 4'b0000;
    zone_temp_comp = 8'h00;

    // Reset state.
    repeat (3) step();
    chk_off("reset_state");
    reset_n = 1'b1;
    repeat (3) step();
    chk_off("post_release_off");

    // Single zone 1 cooling from OFF: IDLE after edge 1, RUN after edge 2.
    zone_power     = 4'b0010;
    zone_temp_comp = 8'b0000_1000;
    step();
    chk_idle("t2_idle_edge1");
    step();
    chk_run("t2_run_edge2", 2'd1, A_COOL);

    // Granted zone loses power at run_cnt=3: immediate release.
    repeat (3) step();
    chk_run("t5_run_cnt3", 2'd1, A_COOL);
    zone_power = 4'b0001;
    step();
    chk_idle("t5_pwr_drop_idle");
    step();
    chk_idle("t5_no_req_idle");
    zone_power = 4'b0000;
    step();
    chk_off("t5_all_off");

    // Zone 2 cooling, then reset mid-RUN.
    zone_power     = 4'b0100;
    zone_temp_comp = 8'b0010_0000;
    step();
    chk_idle("t1_idle");
    step();
    chk_run("t1_run_z2", 2'd2, A_COOL);
    step();
    chk_run("t1_run_z2_hold", 2'd2, A_COOL);
    reset_n = 1'b0;
    #1;
    chk_off("t1_async_reset");
    repeat (2) step();
    chk_off("t1_held_reset");
    zone_power     = 4'b0000;
    zone_temp_comp = 8'h00;
    reset_n        = 1'b1;
    repeat (3) step();
    chk_off("t1_release_off");

    // Zones 0 and 2 both heating: after reset zone 0 wins, then alternation 0,2,0.
    zone_power     = 4'b0101;
    zone_temp_comp = 8'b0001_0001;
    step();
    chk_idle("t3_idle");
    step();
    for (int g = 0; g < 3; g++) begin
      exp_gid = (g == 1) ? 2'd2 : 2'd0;
      chk_run("t3_run_first", exp_gid, A_HEAT);
      for (int c = 0; c < 8; c++) begin
        step();
        chk_run("t3_run_hold", exp_gid, A_HEAT);
      end
      step();
      chk_idle("t3_release_idle");
      step();
    end
    chk_run("t3_next_z2", 2'd2, A_HEAT);

    // Zone 0 cooling, zone 3 takes over in the same mode with no dead time.
    zone_power = 4'b0000;
    step();
    chk_off("t4_off");
    zone_power     = 4'b0001;
    zone_temp_comp = 8'b0000_0010;
    step();
    chk_idle("t4_idle");
    step();
    chk_run("t4_run_z0", 2'd0, A_COOL);
    repeat (8) step();
    chk_run("t4_z0_at_min", 2'd0, A_COOL);
    for (int c = 0; c < 3; c++) begin
      step();
      chk_run("t4_z0_sole_hold", 2'd0, A_COOL);
    end
    zone_power     = 4'b1001;
    zone_temp_comp = 8'b1000_0000;
    step();
    chk_idle("t4_release_idle");
    step();
    chk_run("t4_z3_cool_no_dead", 2'd3, A_COOL);

    // Zone 3 satisfied before MIN_RUN keeps running; then zone 0 cooling again.
    zone_temp_comp = 8'b0000_0010;
    repeat (8) step();
    chk_run("t4_z3_min_run_hold", 2'd3, A_COOL);
    step();
    chk_idle("t4_z3_release");
    step();
    chk_run("t4_z0_cool_again", 2'd0, A_COOL);
    repeat (8) step();

    // Zone 3 now wants heat: changeover inserts four DEAD cycles.
    zone_temp_comp = 8'b0100_0000;
    step();
    chk_idle("t4_chg_idle");
    step();
    chk_dead("t4_dead_1");
    for (int c = 0; c < 3; c++) begin
      step();
      chk_dead("t4_dead_n");
    end
    step();
    chk_idle("t4_after_dead_idle");
    step();
    chk_run("t4_z3_heat", 2'd3, A_HEAT);

    // Mode flip before MIN_RUN keeps the latched cool action.
    zone_power = 4'b0000;
    step();
    chk_off("t6_off");
    zone_power     = 4'b0010;
    zone_temp_comp = 8'b0000_1000;
    step();
    chk_idle("t6_idle");
    step();
    chk_run("t6_run_z1_cool", 2'd1, A_COOL);
    repeat (2) step();
    chk_run("t6_run_cnt2", 2'd1, A_COOL);
    zone_temp_comp = 8'b0000_0100;
    for (int c = 0; c < 6; c++) begin
      step();
      chk_run("t6_flip_still_cool", 2'd1, A_COOL);
    end
    step();
    chk_idle("t6_release_idle");
    step();
    chk_dead("t6_dead_1");
    for (int c = 0; c < 3; c++) begin
      step();
      chk_dead("t6_dead_n");
    end
    step();
    chk_idle("t6_after_dead_idle");
    step();
    chk_run("t6_z1_heat", 2'd1, A_HEAT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
